m_uart_slave: RTL and testbench
===============================

Name: m_uart_slave

Overview:
- UART receive stage, directly downstream of the UART transmitter; consumes its serial TXD line on local input rxd.
- Oversamples rxd, recovers 8N1 frames (LSB first), and presents each byte through a one-entry valid/ready holding register to the MPU-side consumer.
- Flags framing and overrun errors.

Parameters:
- WORD, 8: data bits per frame.
- BAUD_RATE, 115200: line rate in bit/s.
- CLK_FREQ, 16_000_000: clk frequency in Hz.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥4.
- DIV_W, 16: width of the tick divider counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- rxd  in  1  asynchronous serial input; idle high.
- data_o  out  WORD  received byte; valid only while valid=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts data_o when valid&&ready at posedge.
- state  out  3  current FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_HI=5.
- frame_err  out  1  one-cycle pulse on bad stop bit.
- overrun  out  1  one-cycle pulse when a frame is dropped because the holding register is full.
- error  out  1  sticky OR of frame_err, overrun and parity error; cleared only by reset.

Behaviour:
- Reset (reset=0 at posedge):
  - rx_s=1, divider=0, os_cnt=0, bit_cnt=0, state=IDLE.
  - data_o=0, valid=0, frame_err=0, overrun=0, error=0.
- Synchronizer: rxd passes through 2 flops (reset value 1) to give rx_s. All decisions use rx_s only.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated, clamped to ≥1 (defaults: DIV=8).
  - divider counts 0..DIV-1; tick pulses in the cycle divider==DIV-1.
  - divider and os_cnt are forced to 0 in the cycle a start edge is detected.
- IDLE: rx_s==0 → START.
- START:
  - Count ticks until os_cnt reaches OVERSAMPLE/2-1 (mid-bit).
  - Sample there: rx_s==0 → DATA with os_cnt=0, bit_cnt=0.
  - rx_s==1 → IDLE as a glitch; no error raised.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into shift[bit_cnt] (LSB first), then bit_cnt++.
  - After bit WORD-1: go to PARITY if enabled, otherwise STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - rx_s==1 → deliver frame, then IDLE.
  - rx_s==0 → frame_err=1 for 1 cycle, error=1, frame discarded, go to WAIT_HI.
- WAIT_HI: remain until rx_s==1, then IDLE; this blocks false starts during a break condition.
- Deliver, in the cycle after the stop sample:
  - If valid==0, or valid&&ready in that same cycle: data_o←shift, valid=1.
  - Else: overrun=1 for 1 cycle, error=1; data_o and valid keep the old byte; new byte dropped.
- Handshake:
  - valid&&ready with no concurrent delivery → valid=0 next cycle.
  - data_o stays stable while valid=1 && ready=0.
- Latency: valid rises 1 clk after the stop-bit mid-sample tick, i.e. (WORD+1)*OVERSAMPLE*DIV + (OVERSAMPLE/2)*DIV + 3 clk after the falling edge on rxd, ±1 clk.
- Unreachable state encodings → IDLE next cycle; error=1.
- Reset mid-frame: partial frame is lost and outputs return to reset values within the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; the parity bit is sampled after OVERSAMPLE ticks.
  - Even parity is checked: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, the frame is still checked for its stop bit. If the stop bit is good, the frame is discarded (not delivered), error=1, frame_err=1 for 1 cycle, and the FSM goes to IDLE.
- Undefined: PARITY state is never entered; frames are 10 bits.

Test Plan:
- Defaults (DIV=8, 128 clk/bit), ready=1; send 0xA5 8N1 on rxd → valid pulses for 1 cycle with data_o=0xA5; frame_err, overrun and error stay 0.
- ready=0; send 0x3C then 0xC3 back-to-back → data_o=0x3C, valid held, overrun pulses once; error=1; then ready=1 → valid drops with data_o still 0x3C.
- Send 0x55 with the stop bit driven 0 and rxd held low for 3 bit-times → frame_err pulses once, state=5 until rxd high, valid stays 0, no spurious frame afterwards.
- rxd low for 40 clk (less than half a bit) then high → state returns to 0 from 1; no valid, no errors.
- Assert reset for 1 cycle midway through the DATA bits of 0xFF, then send 0x12 → all outputs at reset values; the next frame is received as 0x12.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 → valid, data_o=0x07; send 0x07 with parity bit 0 → no valid, frame_err pulse, error=1.

Source files
------------

// File: rtl/m_uart_slave.sv
// UART receive stage: 2-flop synchronizer, oversampled 8N1 frame recovery, one-entry valid/ready holding register.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module m_uart_slave #(
  parameter int WORD       = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 16_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rxd,
  output logic [WORD-1:0] data_o,
  output logic            valid,
  input  logic            ready,
  output logic [2:0]      state,
  output logic            frame_err,
  output logic            overrun,
  output logic            error
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int BW      = (WORD > 1) ? $clog2(WORD) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  logic            r_rx_meta;
  logic            r_rx_s;
  logic [DIV_W-1:0] r_div;
  logic [OW-1:0]   r_os_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [WORD-1:0] r_shift;
  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_deliver;
  logic [WORD-1:0] r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_error;

  logic w_tick;
  logic w_mid;
  logic w_full;
  logic w_start_det;
  logic w_shift_en;
  logic w_par_smp;
  logic w_stop_smp;
  logic w_deliver_set;
  logic w_ferr_set;
  logic w_ovr_set;
  logic w_bad_state;
  logic w_par_bad;

  assign w_tick = (r_div == DIV_W'(DIV - 1));
  assign w_mid  = w_tick && (r_os_cnt == OW'(OVERSAMPLE / 2 - 1));
  assign w_full = w_tick && (r_os_cnt == OW'(OVERSAMPLE - 1));

  // Synchronizer: everything downstream looks only at r_rx_s.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!r_rx_s) w_next = S_START;
      S_START:   if (w_mid) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_full && (r_bit_cnt == BW'(WORD - 1))) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:  if (w_full) w_next = S_STOP;
`endif
      S_STOP:    if (w_full) w_next = r_rx_s ? S_IDLE : S_WAIT_HI;
      S_WAIT_HI: if (r_rx_s) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_start_det   = (r_state == S_IDLE) && !r_rx_s;
    w_shift_en    = (r_state == S_DATA) && w_full;
`ifdef UART_RX_PARITY_EN
    w_par_smp     = (r_state == S_PARITY) && w_full;
`else
    w_par_smp     = 1'b0;
`endif
    w_stop_smp    = (r_state == S_STOP) && w_full;
    w_deliver_set = w_stop_smp && r_rx_s && !w_par_bad;
    w_ferr_set    = w_stop_smp && (!r_rx_s || w_par_bad);
    w_ovr_set     = r_deliver && r_valid && !ready;
    case (r_state)
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI: w_bad_state = 1'b0;
`ifdef UART_RX_PARITY_EN
      S_PARITY: w_bad_state = 1'b0;
`endif
      default:  w_bad_state = 1'b1;
    endcase
  end

  // Tick divider and oversample counter restart on the start edge so sampling is centred.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div     <= '0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_start_det || w_tick) r_div <= '0;
      else                       r_div <= r_div + 1'b1;

      if (w_start_det) begin
        r_os_cnt <= '0;
      end else if (w_tick) begin
        case (r_state)
          S_START: r_os_cnt <= (r_os_cnt == OW'(OVERSAMPLE / 2 - 1)) ? '0 : r_os_cnt + 1'b1;
          S_DATA, S_PARITY, S_STOP:
                   r_os_cnt <= (r_os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + 1'b1;
          default: r_os_cnt <= '0;
        endcase
      end

      if ((r_state == S_START) && w_mid) r_bit_cnt <= '0;
      else if (w_shift_en)               r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_shift_en) r_shift[r_bit_cnt] <= r_rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  always_ff @(posedge clk) begin
    if (!reset)           r_par_bad <= 1'b0;
    else if (w_start_det) r_par_bad <= 1'b0;
    else if (w_par_smp)   r_par_bad <= (^r_shift) ^ r_rx_s;
  end
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // Handshake: data_o/valid form a one-entry register; a byte is taken when valid && ready
  // at posedge, and a delivery in that same cycle refills it without loss.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_deliver   <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_deliver   <= w_deliver_set;
      r_frame_err <= w_ferr_set;
      r_overrun   <= w_ovr_set;
      r_error     <= r_error | w_ferr_set | w_ovr_set | w_bad_state;
      if (r_deliver && (!r_valid || ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o    = r_data;
  assign valid     = r_valid;
  assign state     = r_state;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign error     = r_error;

endmodule

// File: tb/tb_m_uart_slave.sv
// Testbench for m_uart_slave: directed scenarios plus random bytes, scoreboard-checked.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_m_uart_slave;

  localparam int WORD    = 8;
  localparam int OS      = 16;
  localparam int DIV     = 8;
  localparam int BIT_CLK = OS * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = WORD + 1 + PAR;
  localparam int LAT   = NBITS * BIT_CLK + (OS / 2) * DIV + 3;

  logic            clk;
  logic            rst_n;
  logic            rxd;
  logic            ready;
  logic [WORD-1:0] data_o;
  logic            valid;
  logic [2:0]      state;
  logic            frame_err;
  logic            overrun;
  logic            error;

  int total = 0;
  int bad   = 0;
  logic [WORD-1:0] exp_q[$];
  logic [WORD-1:0] exp_b;
  int  fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  bit  exp_err = 0;
  bit  model_full = 0;
  int  cyc = 0, t_fall = 0, t_rise = 0, valid_hi = 0;
  logic prev_valid = 1'b0;

  m_uart_slave dut (
    .clk(clk), .reset(rst_n), .rxd(rxd), .data_o(data_o), .valid(valid),
    .ready(ready), .state(state), .frame_err(frame_err), .overrun(overrun), .error(error)
  );

  // Clock / reset-independent timekeeping
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard: samples on negedge, inputs move 1 time unit after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !prev_valid) t_rise = cyc;
      if (valid)     valid_hi++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (valid && ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got %02h expected none", data_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (data_o !== exp_b) begin
            bad++;
            $display("FAIL rx_byte: got %02h expected %02h", data_o, exp_b);
          end
        end
      end
    end
    prev_valid = valid;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of one frame from line-level facts only.
  task automatic model_frame(input logic [WORD-1:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok || !par_ok) begin
      exp_fe++;
      exp_err = 1;
    end else if (model_full) begin
      exp_ov++;
      exp_err = 1;
    end else begin
      exp_q.push_back(d);
      if (!ready) model_full = 1;
    end
  endtask

  task automatic drive_bits(input logic v, input int nbits);
    rxd = v;
    step(nbits * BIT_CLK);
  endtask

  task automatic send_frame(input logic [WORD-1:0] d, input logic stop_v, input logic par_v);
    t_fall = cyc;
    drive_bits(1'b0, 1);
    for (int i = 0; i < WORD; i++) drive_bits(d[i], 1);
    if (PAR != 0) drive_bits(par_v, 1);
    drive_bits(stop_v, 1);
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [WORD-1:0] d);
    model_frame(d, 1, 1);
    send_frame(d, 1'b1, ^d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_data"}, int'(data_o), 0);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_ferr"}, int'(frame_err), 0);
    check({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    logic [WORD-1:0] pat;
    int waited;
    rst_n = 1'b0; ready = 1'b1; rxd = 1'b1;
    step(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(20);

    // Single clean byte, latency and one-cycle valid
    valid_hi = 0;
    send_good(8'hA5);
    step(20);
    check_range("latency", t_rise - t_fall, LAT - 1, LAT + 1);
    check("valid_width", valid_hi, 1);
    check("t1_error", int'(error), 0);
    check("t1_ferr_cnt", fe_cnt, exp_fe);

    // Short low glitch on the line
    rxd = 1'b0;
    step(20);
    check("glitch_in_start", int'(state), 1);
    step(20);
    rxd = 1'b1;
    step(60);
    check("glitch_back_idle", int'(state), 0);
    check("glitch_no_valid", valid_hi, 1);
    check("glitch_error", int'(error), 0);

    // Overrun with consumer stalled
    ready = 1'b0;
    send_good(8'h3C);
    send_good(8'hC3);
    step(10);
    check("ovr_valid_held", int'(valid), 1);
    check("ovr_data_held", int'(data_o), 8'h3C);
    check("ovr_cnt", ov_cnt, exp_ov);
    check("ovr_error", int'(error), int'(exp_err));
    ready = 1'b1;
    model_full = 0;
    step(2);
    check("ovr_valid_drop", int'(valid), 0);
    check("ovr_data_after", int'(data_o), 8'h3C);

    // Bad stop bit followed by a break
    pat = 8'h55;
    model_frame(pat, 0, 1);
    drive_bits(1'b0, 1);
    for (int i = 0; i < WORD; i++) drive_bits(pat[i], 1);
    if (PAR != 0) drive_bits(^pat, 1);
    drive_bits(1'b0, 1);
    step(BIT_CLK);
    check("break_wait_hi", int'(state), 5);
    step(BIT_CLK);
    rxd = 1'b1;
    step(10);
    check("break_idle", int'(state), 0);
    check("break_ferr_cnt", fe_cnt, exp_fe);
    check("break_no_valid", int'(valid), 0);
    step(300);

    // Reset in the middle of a frame
    drive_bits(1'b0, 1);
    drive_bits(1'b1, 4);
    rst_n = 1'b0;
    step(1);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    exp_err = 0;
    model_full = 0;
    drive_bits(1'b1, 4 + PAR + 1);
    step(50);
    send_good(8'h12);
    step(20);
    check("post_reset_error", int'(error), 0);

    // Random bytes with random idle gaps
    for (int n = 0; n < 12; n++) begin
      send_good(WORD'($urandom_range(0, 255)));
      step($urandom_range(0, 40));
    end

`ifdef UART_RX_PARITY_EN
    model_frame(8'h07, 1, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    step(20);
    model_frame(8'h07, 1, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    step(20);
    check("par_ferr_cnt", fe_cnt, exp_fe);
    check("par_error", int'(error), 1);
    check("par_no_valid", int'(valid), 0);
`endif

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      step(1);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("final_ferr_cnt", fe_cnt, exp_fe);
    check("final_ovr_cnt", ov_cnt, exp_ov);
    check("final_error", int'(error), int'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
